// File: rtl/mul_pkg.sv
// Shared encodings for the iterative multiplier: operation codes and FSM states.
package mul_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MADD = 2'b01;
    localparam logic [1:0] OP_MSUB = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: retires BPC multiplier bits into the partial product.
module mul_step #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic [2*WIDTH-1:0] i_prod,
    input  logic [2*WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0]   i_mplier,
    output logic [2*WIDTH-1:0] o_prod,
    output logic [2*WIDTH-1:0] o_mcand,
    output logic [WIDTH-1:0]   o_mplier
);

    logic [2*WIDTH-1:0] w_digit;
    logic [2*WIDTH-1:0] w_term;

    // The multiplicand is kept pre-shifted, so the digit weight is already applied.
    assign w_digit  = {{(2*WIDTH-BPC){1'b0}}, i_mplier[BPC-1:0]};
    assign w_term   = i_mcand * w_digit;
    assign o_prod   = i_prod + w_term;
    assign o_mcand  = i_mcand << BPC;
    assign o_mplier = i_mplier >> BPC;

endmodule

// File: rtl/mul_iter.sv
// Iterative signed/unsigned multiplier with multiply-add/subtract accumulator.
module mul_iter
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sign,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_a,
    input  logic [WIDTH-1:0]   data_b,
    input  logic               acc_load,
    input  logic [2*WIDTH-1:0] acc_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] data_c
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = $clog2(N + 1);

    state_e             r_state;
    state_e             w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic [1:0]         r_op;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_c;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_step_prod;
    logic [2*WIDTH-1:0] w_step_mcand;
    logic [WIDTH-1:0]   w_step_mplier;
    logic               w_sub;
    logic [2*WIDTH-1:0] w_base;
    logic [2*WIDTH-1:0] w_fin;

    // Magnitudes are unsigned WIDTH-bit, so the most-negative operand stays exact.
    assign w_mag_a = (sign && data_a[WIDTH-1]) ? -data_a : data_a;
    assign w_mag_b = (sign && data_b[WIDTH-1]) ? -data_b : data_b;

    mul_step #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_step (
        .i_prod   (r_prod),
        .i_mcand  (r_mcand),
        .i_mplier (r_mplier),
        .o_prod   (w_step_prod),
        .o_mcand  (w_step_mcand),
        .o_mplier (w_step_mplier)
    );

    // Result sign and accumulate direction fold into one add/subtract.
    assign w_sub  = r_neg ^ (r_op == OP_MSUB);
    assign w_base = (r_op == OP_MADD || r_op == OP_MSUB) ? r_c : '0;
    assign w_fin  = w_sub ? (w_base - r_prod) : (w_base + r_prod);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_CALC;
            ST_CALC: if (r_cnt == CW'(1)) w_next = ST_FIN;
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_op     <= OP_MUL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_c      <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (r_state == ST_FIN);
            case (r_state)
                ST_IDLE: begin
                    if (acc_load) r_c <= acc_in;
                    if (start) begin
                        r_op     <= op;
                        r_neg    <= sign & (data_a[WIDTH-1] ^ data_b[WIDTH-1]);
                        r_prod   <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_cnt    <= CW'(N);
                    end
                end
                ST_CALC: begin
                    r_prod   <= w_step_prod;
                    r_mcand  <= w_step_mcand;
                    r_mplier <= w_step_mplier;
                    r_cnt    <= r_cnt - CW'(1);
                end
                ST_FIN:  r_c <= w_fin;
                default: ;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign data_c = r_c;

endmodule

// File: tb/tb_mul_iter.sv
// Bench: three mul_iter instances (BPC 1, 2, 4) driven in lockstep against an arithmetic model.
module tb_mul_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign;
    logic [1:0]  op;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        acc_load;
    logic [63:0] acc_in;
    logic [2:0]  busy_w;
    logic [2:0]  done_w;
    logic [63:0] c_w [3];

    int          n_chk;
    int          n_fail;
    logic [63:0] mdl;
    int          lat_exp [3];

    mul_iter #(.WIDTH(32), .BPC(1)) u_b1 (
        .clk(clk), .rst(rst), .start(start), .sign(sign), .op(op),
        .data_a(data_a), .data_b(data_b), .acc_load(acc_load), .acc_in(acc_in),
        .busy(busy_w[0]), .done(done_w[0]), .data_c(c_w[0]));

    mul_iter #(.WIDTH(32), .BPC(2)) u_b2 (
        .clk(clk), .rst(rst), .start(start), .sign(sign), .op(op),
        .data_a(data_a), .data_b(data_b), .acc_load(acc_load), .acc_in(acc_in),
        .busy(busy_w[1]), .done(done_w[1]), .data_c(c_w[1]));

    mul_iter #(.WIDTH(32), .BPC(4)) u_b4 (
        .clk(clk), .rst(rst), .start(start), .sign(sign), .op(op),
        .data_a(data_a), .data_b(data_b), .acc_load(acc_load), .acc_in(acc_in),
        .busy(busy_w[2]), .done(done_w[2]), .data_c(c_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [63:0] c, input logic s,
                                          input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = {32'h0, a} * {32'h0, b};
        case (o)
            2'b01:   return c + p;
            2'b10:   return c - p;
            default: return p;
        endcase
    endfunction

    task automatic do_op(input logic s, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit ld, input logic [63:0] ldv,
                         input int disturb, input string name);
        int          lat [3];
        int          cnt [3];
        logic [63:0] got [3];
        if (ld) mdl = ldv;
        mdl = model(mdl, s, o, a, b);
        sign = s; op = o; data_a = a; data_b = b;
        acc_load = ld; acc_in = ldv; start = 1'b1;
        for (int k = 0; k < 3; k++) begin lat[k] = -1; cnt[k] = 0; got[k] = '0; end
        @(posedge clk); #1;
        start = 1'b0; acc_load = 1'b0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(posedge clk); #1;
            if (cyc == disturb) begin
                start = 1'b1; acc_load = 1'b1; acc_in = 64'hDEAD_BEEF;
                data_a = $urandom; data_b = $urandom; op = 2'b01; sign = ~s;
            end else begin
                start = 1'b0; acc_load = 1'b0;
            end
            for (int k = 0; k < 3; k++) begin
                if (done_w[k]) begin
                    cnt[k]++;
                    if (lat[k] < 0) begin lat[k] = cyc; got[k] = c_w[k]; end
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (lat[k] !== lat_exp[k]) begin
                n_fail++;
                $display("FAIL %s dut%0d latency: got %0d expected %0d", name, k, lat[k], lat_exp[k]);
            end
            n_chk++;
            if (cnt[k] !== 1) begin
                n_fail++;
                $display("FAIL %s dut%0d done pulses: got %0d expected 1", name, k, cnt[k]);
            end
            n_chk++;
            if (got[k] !== mdl) begin
                n_fail++;
                $display("FAIL %s dut%0d data_c at done: got %h expected %h", name, k, got[k], mdl);
            end
            n_chk++;
            if (c_w[k] !== mdl || busy_w[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s dut%0d hold/idle: data_c %h busy %b expected %h busy 0",
                         name, k, c_w[k], busy_w[k], mdl);
            end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (busy_w[k] !== 1'b0 || done_w[k] !== 1'b0 || c_w[k] !== 64'h0) begin
                n_fail++;
                $display("FAIL reset dut%0d: busy %b done %b data_c %h expected 0 0 0",
                         k, busy_w[k], done_w[k], c_w[k]);
            end
        end
    endtask

    task automatic test_vectors();
        do_op(1'b1, 2'b00, 32'hFFFF0001, 32'd3, 1'b0, 64'h0, 0, "smul_neg");
        do_op(1'b0, 2'b00, 32'hFFFF0001, 32'd3, 1'b0, 64'h0, 0, "umul");
        do_op(1'b1, 2'b00, 32'h80000000, 32'h80000000, 1'b0, 64'h0, 0, "smul_minmin");
        do_op(1'b1, 2'b00, 32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h0, 0, "smul_min_m1");
        do_op(1'b0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'h0, 0, "op11_umax");
    endtask

    task automatic test_accum();
        acc_load = 1'b1; acc_in = 64'h10;
        @(posedge clk); #1;
        acc_load = 1'b0;
        mdl = 64'h10;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (c_w[k] !== 64'h10) begin
                n_fail++;
                $display("FAIL acc_load dut%0d: got %h expected 0000000000000010", k, c_w[k]);
            end
        end
        do_op(1'b1, 2'b01, 32'd2, 32'd3, 1'b0, 64'h0, 0, "madd_2x3");
        do_op(1'b1, 2'b10, 32'd1, 32'd1, 1'b0, 64'h0, 0, "msub_1x1");
        do_op(1'b1, 2'b10, 32'h16, 32'd1, 1'b0, 64'h0, 0, "msub_wrap");
        do_op(1'b1, 2'b01, 32'hFFFFFFFE, 32'd5, 1'b1, 64'h100, 0, "load_and_madd");
    endtask

    task automatic test_busy_ignore();
        do_op(1'b1, 2'b00, 32'h12345678, 32'hFEDCBA98, 1'b0, 64'h0, 4, "start_mid_calc");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) a = 32'h80000000;
            if (i % 4 == 2) b = 32'h0;
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, b,
                  ($urandom_range(0, 3) == 0), {$urandom, $urandom}, 0, "random");
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        sign = 1'b0; op = 2'b00; data_a = 32'hABCD; data_b = 32'h1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1; acc_load = 1'b1; acc_in = 64'h55;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; acc_load = 1'b0;
        mdl = 64'h0;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (busy_w[k] !== 1'b0 || done_w[k] !== 1'b0 || c_w[k] !== 64'h0) begin
                n_fail++;
                $display("FAIL abort dut%0d: busy %b done %b data_c %h expected 0 0 0",
                         k, busy_w[k], done_w[k], c_w[k]);
            end
        end
        seen = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (done_w !== 3'b000) seen++;
        end
        n_chk++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done cycles expected 0", seen);
        end
        do_op(1'b1, 2'b01, 32'hFFFFFFF9, 32'd6, 1'b0, 64'h0, 0, "after_abort");
    endtask

    initial begin
        n_chk = 0; n_fail = 0; mdl = 64'h0;
        lat_exp[0] = 33; lat_exp[1] = 17; lat_exp[2] = 9;
        rst = 1'b1; start = 1'b0; sign = 1'b0; op = 2'b00;
        data_a = '0; data_b = '0; acc_load = 1'b0; acc_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_vectors();
        test_accum();
        test_busy_ignore();
        test_random();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_iter.md
MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; SHALL be an even value of at least 8.
REQ-002 Parameter BPC, default 1, multiplier bits retired per cycle; SHALL be 1, 2 or 4 and SHALL divide WIDTH.
REQ-003 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: requests an operation; sampled only in IDLE.
REQ-006 Port sign, input, 1: 1 treats operands as two's complement; 0 treats them as unsigned. Captured with start.
REQ-007 Port op, input, 2: 00 MUL, 01 MADD, 10 MSUB, 11 treated as MUL. Captured with start.
REQ-008 Port data_a, input, WIDTH: multiplicand, captured with start.
REQ-009 Port data_b, input, WIDTH: multiplier, captured with start.
REQ-010 Port acc_load, input, 1: loads acc_in into data_c; honoured only in IDLE.
REQ-011 Port acc_in, input, 2*WIDTH: value written into data_c by acc_load.
REQ-012 Port busy, output, 1: high in CALC and FIN.
REQ-013 Port done, output, 1: single-cycle pulse in FIN.
REQ-014 Port data_c, output, 2*WIDTH: registered result/accumulator (HI = upper WIDTH bits, LO = lower); holds its value between updates.

Function
REQ-015 States: IDLE, CALC, FIN; IDLE->CALC on start; CALC->FIN after N=WIDTH/BPC cycles; FIN->IDLE unconditionally.
REQ-016 On start in IDLE, latch op and sign, latch |data_a| and |data_b| (magnitudes when sign=1, raw values otherwise), set neg = sign & (a[MSB] ^ b[MSB]), clear the partial product, load the step counter with N.
REQ-017 Each CALC cycle: add (magnitude_a x low BPC bits of the multiplier) into the partial product, shift the multiplier right by BPC, decrement the counter; leave CALC when the counter reaches 0.
REQ-018 In FIN: P = neg ? -prod : prod, taken modulo 2^(2*WIDTH). data_c <= P for MUL, data_c + P for MADD, data_c - P for MSUB; all arithmetic wraps at 2*WIDTH bits with no overflow flag.
REQ-019 Latency: start sampled at edge 0; done is high and data_c is updated in the cycle after edge N+1. With WIDTH=32 and BPC=1 this is 33 cycles.
REQ-020 start while busy is ignored and has no side effects; start is accepted again on the cycle after FIN.
REQ-021 acc_load while busy is ignored; data_c changes only in FIN or on acc_load in IDLE.
REQ-022 acc_load and start together in IDLE: the load takes effect and the operation starts; MADD/MSUB accumulate onto the loaded value.
REQ-023 The most-negative operand SHALL use an unsigned WIDTH-bit magnitude, so 0x80000000 x 0x80000000 signed (WIDTH=32) gives 0x4000000000000000.
REQ-024 busy and done SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-025 rst SHALL force IDLE, with busy=0, done=0, data_c=0, counter=0, and all internal operand and partial-product registers cleared.
REQ-026 rst asserted during CALC or FIN SHALL abort the operation with no done pulse and data_c=0; it takes priority over start and acc_load.

Structure
REQ-027 Shared package mul_pkg SHALL define the op encodings (MUL, MADD, MSUB) and the state encoding; there SHALL be no other shared constants.
REQ-028 Sub-module mul_step (combinational) SHALL compute one CALC iteration: partial-product add plus multiplier shift for BPC bits. mul_iter SHALL instantiate it once.
REQ-029 The datapath SHALL use one 2*WIDTH-bit adder for CALC, plus one 2*WIDTH-bit adder/subtractor for FIN.

Verification
REQ-030 WIDTH=32, BPC=1, sign=1, MUL, a=0xFFFF0001, b=3 -> done exactly 33 cycles after start, data_c=0xFFFFFFFFFFFD0003.
REQ-031 Same operands with sign=0 -> data_c=0x00000002FFFD0003; the run SHALL repeat with BPC=2 and BPC=4 and give the same results at 17 and 9 cycles.
REQ-032 acc_load with acc_in=0x10, then MADD signed 2x3 -> data_c=0x16; then MSUB signed 1x1 -> data_c=0x15; a subsequent MSUB 0x16x1 from 0x15 -> data_c=0xFFFFFFFFFFFFFFFF.
REQ-033 Signed 0x80000000 x 0x80000000 -> 0x4000000000000000; signed 0x80000000 x 0xFFFFFFFF -> 0x0000000080000000.
REQ-034 start pulsed mid-CALC with different operands -> ignored, first result unchanged; acc_load mid-CALC -> ignored.
REQ-035 rst asserted 10 cycles into CALC -> next cycle busy=0, data_c=0, and no done pulse; a following start completes normally.
